// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - default sizes and FSM state type for the systolic array controller
package systolic_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_MW = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WLOAD   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/systolic_out_tracker.sv
// rtl/systolic_out_tracker.sv - N-deep {valid,row} delay line marking when bottom-row results emerge
module systolic_out_tracker
  import systolic_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int MW = DEF_MW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [MW-1:0] in_row,
  output logic          out_valid,
  output logic [MW-1:0] out_row
);

  logic [N-1:0]  valid_q;
  logic [MW-1:0] row_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) row_q[i] <= '0;
    end else begin
      valid_q  <= {valid_q[N-2:0], in_valid};
      row_q[0] <= in_row;
      for (int i = 1; i < N; i++) row_q[i] <= row_q[i-1];
    end
  end

  assign out_valid = valid_q[N-1];
  assign out_row   = row_q[N-1];

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - systolic array job sequencer (weight load, compute, drain); SYSTOLIC_CTRL_WREUSE_EN adds keep_weights
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int MW = DEF_MW
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SYSTOLIC_CTRL_WREUSE_EN
  input  logic                 keep_weights,
`endif
  input  logic                 start,
  input  logic [MW-1:0]        num_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 wshift,
  output logic                 pe_en,
  output logic                 mul_en,
  output logic                 adder_en,
  output logic                 w_rd_en,
  output logic [$clog2(N)-1:0] w_rd_addr,
  output logic                 i_rd_en,
  output logic [MW-1:0]        i_rd_addr,
  output logic                 out_valid,
  output logic [MW-1:0]        out_row
);

  localparam int            AW        = $clog2(N);
  localparam logic [MW-1:0] CNT_NLAST = MW'(N - 1);
  localparam logic [AW-1:0] W_LAST    = AW'(N - 1);

  state_e        state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] m_q, m_d;
  logic          keep;

  logic          busy_d, done_d, wshift_d, pe_en_d, mul_en_d, adder_en_d;
  logic          w_rd_en_d, i_rd_en_d;
  logic [AW-1:0] w_rd_addr_d;
  logic [MW-1:0] i_rd_addr_d;

`ifdef SYSTOLIC_CTRL_WREUSE_EN
  assign keep = keep_weights;
`else
  assign keep = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = num_rows;
          cnt_d = '0;
          if (num_rows == '0)  state_d = DONE;
          else if (keep)       state_d = COMPUTE;
          else                 state_d = WLOAD;
        end
      end
      WLOAD: begin
        if (cnt_q == CNT_NLAST) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MW'(1);
        end
      end
      COMPUTE: begin
        // compare against M-1 so M = 2^MW-1 ends without the counter wrapping
        if (cnt_q == m_q - MW'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_NLAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    wshift_d    = 1'b0;
    pe_en_d     = 1'b0;
    mul_en_d    = 1'b0;
    adder_en_d  = 1'b0;
    w_rd_en_d   = 1'b0;
    i_rd_en_d   = 1'b0;
    w_rd_addr_d = '0;
    i_rd_addr_d = '0;
    case (state_d)
      WLOAD: begin
        wshift_d    = 1'b1;
        pe_en_d     = 1'b1;
        w_rd_en_d   = 1'b1;
        w_rd_addr_d = W_LAST - cnt_d[AW-1:0];
      end
      COMPUTE: begin
        pe_en_d     = 1'b1;
        mul_en_d    = 1'b1;
        adder_en_d  = 1'b1;
        i_rd_en_d   = 1'b1;
        i_rd_addr_d = cnt_d;
      end
      DRAIN: begin
        pe_en_d    = 1'b1;
        mul_en_d   = 1'b1;
        adder_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wshift    <= 1'b0;
      pe_en     <= 1'b0;
      mul_en    <= 1'b0;
      adder_en  <= 1'b0;
      w_rd_en   <= 1'b0;
      i_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      i_rd_addr <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      busy      <= busy_d;
      done      <= done_d;
      wshift    <= wshift_d;
      pe_en     <= pe_en_d;
      mul_en    <= mul_en_d;
      adder_en  <= adder_en_d;
      w_rd_en   <= w_rd_en_d;
      i_rd_en   <= i_rd_en_d;
      w_rd_addr <= w_rd_addr_d;
      i_rd_addr <= i_rd_addr_d;
    end
  end

  systolic_out_tracker #(
    .N  (N),
    .MW (MW)
  ) u_out_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (i_rd_en),
    .in_row    (i_rd_addr),
    .out_valid (out_valid),
    .out_row   (out_row)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking scoreboard bench for systolic_ctrl
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int MW = 8;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          keep_weights;
  logic [MW-1:0] num_rows;
  logic          busy, done, wshift, pe_en, mul_en, adder_en;
  logic          w_rd_en, i_rd_en, out_valid;
  logic [AW-1:0] w_rd_addr;
  logic [MW-1:0] i_rd_addr, out_row;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    int cyc;
    int row;
  } ev_t;

  int  q_w[$];
  int  q_i[$];
  ev_t q_o[$];

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .MW(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SYSTOLIC_CTRL_WREUSE_EN
    .keep_weights (keep_weights),
`endif
    .start        (start),
    .num_rows     (num_rows),
    .busy         (busy),
    .done         (done),
    .wshift       (wshift),
    .pe_en        (pe_en),
    .mul_en       (mul_en),
    .adder_en     (adder_en),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .i_rd_en      (i_rd_en),
    .i_rd_addr    (i_rd_addr),
    .out_valid    (out_valid),
    .out_row      (out_row)
  );

  function automatic logic [31:0] outs_vec();
    return {busy, done, wshift, pe_en, mul_en, adder_en, w_rd_en, i_rd_en,
            out_valid, w_rd_addr, i_rd_addr, out_row};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_rows = '0; keep_weights = 1'b0;
    #2;
    checks++;
    if (outs_vec() !== 32'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", outs_vec());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=0", outs_vec());
    end
  endtask

  // Runs one job from an IDLE negedge; the scoreboard is loaded at start, drained as the DUT emits.
  task automatic run_job(input int m, input bit keep, input bit poke, input string name);
    int   w, t, done_cyc, exp_i;
    bit   wl, cp, dr, dn, bz;
    logic [7:0] exp_v, got_v;
    ev_t  e;
    w = keep ? 0 : N;
    t = (m == 0) ? 1 : w + m + N + 1;
    q_w.delete(); q_i.delete(); q_o.delete();
    if (m != 0) begin
      for (int k = 0; k < w; k++) q_w.push_back(N - 1 - k);
      for (int r = 0; r < m; r++) begin
        q_i.push_back(r);
        e.cyc = w + 1 + r + N;
        e.row = r;
        q_o.push_back(e);
      end
    end
    start = 1'b1; num_rows = MW'(m); keep_weights = keep;
    done_cyc = -1;
    for (int c = 1; c <= t + 2; c++) begin
      @(negedge clk);
      start = 1'b0; keep_weights = 1'b0; num_rows = MW'($urandom);
      if (m == 0) begin
        wl = 0; cp = 0; dr = 0; dn = (c == 1); bz = (c == 1);
      end else begin
        wl = (c >= 1) && (c <= w);
        cp = (c >= w + 1) && (c <= w + m);
        dr = (c >= w + m + 1) && (c <= w + m + N);
        dn = (c == t);
        bz = (c <= t);
      end
      exp_v = {bz, dn, wl, wl | cp | dr, cp | dr, cp | dr, wl, cp};
      got_v = {busy, done, wshift, pe_en, mul_en, adder_en, w_rd_en, i_rd_en};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s ctl c=%0d got=%b exp=%b", name, c, got_v, exp_v);
      end
      if (w_rd_en === 1'b1) begin
        checks++;
        if (q_w.size() == 0) begin
          failures++;
          $display("FAIL %s w_extra c=%0d got=%0d exp=none", name, c, w_rd_addr);
        end else begin
          exp_i = q_w.pop_front();
          if (int'(w_rd_addr) != exp_i) begin
            failures++;
            $display("FAIL %s w_rd_addr c=%0d got=%0d exp=%0d", name, c, w_rd_addr, exp_i);
          end
        end
      end
      if (i_rd_en === 1'b1) begin
        checks++;
        if (q_i.size() == 0) begin
          failures++;
          $display("FAIL %s i_extra c=%0d got=%0d exp=none", name, c, i_rd_addr);
        end else begin
          exp_i = q_i.pop_front();
          if (int'(i_rd_addr) != exp_i) begin
            failures++;
            $display("FAIL %s i_rd_addr c=%0d got=%0d exp=%0d", name, c, i_rd_addr, exp_i);
          end
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q_o.size() == 0) begin
          failures++;
          $display("FAIL %s out_extra c=%0d got=%0d exp=none", name, c, out_row);
        end else begin
          e = q_o.pop_front();
          if (int'(out_row) != e.row || c != e.cyc) begin
            failures++;
            $display("FAIL %s out_row c=%0d got=%0d exp=%0d@%0d", name, c, out_row, e.row, e.cyc);
          end
        end
      end
      if (done === 1'b1) done_cyc = c;
      if (poke && (c == 2 || c == w + 1 || c == t)) begin
        start = 1'b1; num_rows = MW'(5);
      end
    end
    start = 1'b0;
    checks++;
    if (done_cyc != t) begin
      failures++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, t);
    end
    checks++;
    if (q_w.size() + q_i.size() + q_o.size() != 0) begin
      failures++;
      $display("FAIL %s leftover got=%0d/%0d/%0d exp=0/0/0", name, q_w.size(), q_i.size(), q_o.size());
    end
  endtask

  task automatic test_basic();
    run_job(3, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_zero_rows();
    run_job(0, 1'b0, 1'b0, "zero_rows");
  endtask

  task automatic test_start_ignored();
    run_job(3, 1'b0, 1'b1, "start_ignored");
  endtask

  task automatic test_back_to_back();
    run_job(1, 1'b0, 1'b0, "b2b_m1");
    run_job(2, 1'b0, 1'b0, "b2b_m2");
  endtask

  task automatic test_max_rows();
    run_job(255, 1'b0, 1'b0, "max_rows");
  endtask

  task automatic test_reset_midjob();
    int bad;
    start = 1'b1; num_rows = MW'(3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (i_rd_en !== 1'b1 || i_rd_addr !== MW'(1)) begin
      failures++;
      $display("FAIL midrst_pre got=%b/%0d exp=1/1", i_rd_en, i_rd_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs_vec() !== 32'd0) begin
      failures++;
      $display("FAIL midrst_async got=%h exp=0", outs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((busy | done | out_valid | pe_en) !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_after got=%0d active cycles exp=0", bad);
    end
  endtask

`ifdef SYSTOLIC_CTRL_WREUSE_EN
  task automatic test_wreuse();
    run_job(2, 1'b1, 1'b0, "wreuse");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_start_ignored();
    test_back_to_back();
    test_reset_midjob();
    test_max_rows();
`ifdef SYSTOLIC_CTRL_WREUSE_EN
    test_wreuse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
